// File: rtl/sram_device_model_if.sv
// SRAM pin bundle between an SRAM controller (master) and the device model (slave).
// Address and active-low strobes only; the bidirectional DQ bus stays a plain inout net.
interface sram_device_model_if;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_WE_N;
    logic        SRAM_UB_N;
    logic        SRAM_LB_N;
    logic        SRAM_CE_N;
    logic        SRAM_OE_N;

    modport master (
        output SRAM_ADDR, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N
    );

    modport slave (
        input  SRAM_ADDR, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N
    );
endinterface

// File: rtl/sram_device_model.sv
// Clocked behavioural model of a 256Kx16 asynchronous SRAM seen from its pins.
// Optional `SRAM_PROTOCOL_CHECK_EN adds a sticky protocol violation flag on protocol_err.
module sram_device_model #(
    parameter int MEM_DEPTH    = 262144,
    parameter int READ_LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst,
    sram_device_model_if.slave  bus,
    inout  wire  [15:0]         SRAM_DQ,
    output logic                rd_valid,
    output logic                wr_commit,
    output logic                protocol_err
);
    localparam int AW    = $clog2(MEM_DEPTH);
    localparam int CNT_W = $clog2(READ_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(READ_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_READ_WAIT  = 2'd1,
        S_READ_DRIVE = 2'd2,
        S_WRITE_HOLD = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nx;
    logic [17:0]        r_addr;
    logic [15:0]        r_wdata;
    logic               r_ub_n;
    logic               r_lb_n;
    logic [15:0]        r_dout;
    logic               r_dq_en_hi;
    logic               r_dq_en_lo;
    logic               r_rd_valid;
    logic               r_wr_commit;
    logic               w_wr_cond;
    logic               w_rd_cond;
    logic               w_addr_same;
    logic               w_rd_latch;
    logic               w_capture;
    logic               w_commit;
    logic [15:0]        r_mem [MEM_DEPTH];

    assign w_wr_cond   = !bus.SRAM_CE_N && !bus.SRAM_WE_N;
    assign w_rd_cond   = !bus.SRAM_CE_N &&  bus.SRAM_WE_N && !bus.SRAM_OE_N;
    assign w_addr_same = (bus.SRAM_ADDR == r_addr);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next state, stable-address counter and datapath strobes; write wins over read
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_rd_latch = 1'b0;
        w_capture  = 1'b0;
        w_commit   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_wr_cond) begin
                    w_state_nx = S_WRITE_HOLD;
                    w_cnt_nx   = CNT_ZERO;
                end else if (w_rd_cond) begin
                    w_state_nx = S_READ_WAIT;
                    w_cnt_nx   = CNT_ONE;
                    w_rd_latch = 1'b1;
                end else begin
                    w_cnt_nx   = CNT_ZERO;
                end
            end
            S_WRITE_HOLD: begin
                if (w_wr_cond) begin
                    w_state_nx = S_WRITE_HOLD;
                end else begin
                    w_commit = 1'b1;
                    if (w_rd_cond) begin
                        w_state_nx = S_READ_WAIT;
                        w_cnt_nx   = CNT_ONE;
                        w_rd_latch = 1'b1;
                    end else begin
                        w_state_nx = S_IDLE;
                        w_cnt_nx   = CNT_ZERO;
                    end
                end
            end
            S_READ_WAIT, S_READ_DRIVE: begin
                if (w_wr_cond) begin
                    w_state_nx = S_WRITE_HOLD;
                    w_cnt_nx   = CNT_ZERO;
                end else if (!w_rd_cond) begin
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = CNT_ZERO;
                end else if (!w_addr_same) begin
                    w_state_nx = S_READ_WAIT;
                    w_cnt_nx   = CNT_ONE;
                    w_rd_latch = 1'b1;
                end else if (r_state == S_READ_DRIVE) begin
                    w_state_nx = S_READ_DRIVE;
                end else if (r_cnt >= CNT_MAX) begin
                    w_state_nx = S_READ_DRIVE;
                    w_capture  = 1'b1;
                end else begin
                    w_cnt_nx   = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_cnt_nx   = CNT_ZERO;
            end
        endcase
    end

    // Latched address/write data, lane drive enables and status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= CNT_ZERO;
            r_addr      <= 18'd0;
            r_wdata     <= 16'd0;
            r_ub_n      <= 1'b1;
            r_lb_n      <= 1'b1;
            r_dq_en_hi  <= 1'b0;
            r_dq_en_lo  <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_wr_commit <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nx;
            r_dq_en_hi  <= (w_state_nx == S_READ_DRIVE) && !bus.SRAM_UB_N;
            r_dq_en_lo  <= (w_state_nx == S_READ_DRIVE) && !bus.SRAM_LB_N;
            r_rd_valid  <= (w_state_nx == S_READ_DRIVE);
            r_wr_commit <= w_commit;
            if (w_wr_cond) begin
                r_addr  <= bus.SRAM_ADDR;
                r_wdata <= SRAM_DQ;
                r_ub_n  <= bus.SRAM_UB_N;
                r_lb_n  <= bus.SRAM_LB_N;
            end else if (w_rd_latch) begin
                r_addr  <= bus.SRAM_ADDR;
            end
        end
    end

    // Storage array and read capture; deliberately never reset
    always_ff @(posedge clk) begin
        if (w_commit) begin
            if (!r_ub_n) begin
                r_mem[r_addr[AW-1:0]][15:8] <= r_wdata[15:8];
            end
            if (!r_lb_n) begin
                r_mem[r_addr[AW-1:0]][7:0] <= r_wdata[7:0];
            end
        end
        if (w_capture) begin
            r_dout <= r_mem[r_addr[AW-1:0]];
        end
    end

    assign SRAM_DQ[15:8] = r_dq_en_hi ? r_dout[15:8] : 8'hzz;
    assign SRAM_DQ[7:0]  = r_dq_en_lo ? r_dout[7:0]  : 8'hzz;
    assign rd_valid      = r_rd_valid;
    assign wr_commit     = r_wr_commit;

`ifdef SRAM_PROTOCOL_CHECK_EN
    logic        r_prot_err;
    logic        r_chk_wr;
    logic        r_chk_ce_n;
    logic        r_chk_we_n;
    logic        r_chk_oe_n;
    logic        r_chk_ub_n;
    logic        r_chk_lb_n;
    logic [17:0] r_chk_addr;
    logic        w_viol_addr;
    logic        w_viol_bus;
    logic        w_viol_idle;

    // Violations judged against the previous cycle's pin sample
    always_comb begin
        w_viol_addr = r_chk_wr && w_wr_cond &&
                      ((bus.SRAM_ADDR != r_chk_addr) ||
                       (bus.SRAM_UB_N != r_chk_ub_n) || (bus.SRAM_LB_N != r_chk_lb_n));
        w_viol_bus  = w_wr_cond && (r_dq_en_hi || r_dq_en_lo);
        w_viol_idle = r_chk_ce_n && bus.SRAM_CE_N &&
                      r_chk_ub_n && r_chk_lb_n && bus.SRAM_UB_N && bus.SRAM_LB_N &&
                      ((bus.SRAM_WE_N != r_chk_we_n) || (bus.SRAM_OE_N != r_chk_oe_n)) &&
                      !(r_chk_we_n && bus.SRAM_WE_N);
    end

    // Previous-cycle pin sample and sticky error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prot_err <= 1'b0;
            r_chk_wr   <= 1'b0;
            r_chk_ce_n <= 1'b0;
            r_chk_we_n <= 1'b1;
            r_chk_oe_n <= 1'b1;
            r_chk_ub_n <= 1'b0;
            r_chk_lb_n <= 1'b0;
            r_chk_addr <= 18'd0;
        end else begin
            r_prot_err <= r_prot_err || w_viol_addr || w_viol_bus || w_viol_idle;
            r_chk_wr   <= w_wr_cond;
            r_chk_ce_n <= bus.SRAM_CE_N;
            r_chk_we_n <= bus.SRAM_WE_N;
            r_chk_oe_n <= bus.SRAM_OE_N;
            r_chk_ub_n <= bus.SRAM_UB_N;
            r_chk_lb_n <= bus.SRAM_LB_N;
            r_chk_addr <= bus.SRAM_ADDR;
        end
    end

    assign protocol_err = r_prot_err;
`else
    assign protocol_err = 1'b0;
`endif
endmodule

// File: tb/tb_sram_device_model.sv
// Directed bench for sram_device_model (MEM_DEPTH=1024, READ_LATENCY=3); undriven DQ lanes pull to 1.
module tb_sram_device_model;
    localparam int DEPTH = 1024;
    localparam int RL    = 3;
`ifdef SRAM_PROTOCOL_CHECK_EN
    localparam logic PROT_EXP = 1'b1;
`else
    localparam logic PROT_EXP = 1'b0;
`endif

    typedef struct {
        logic        do_wr;
        logic [17:0] waddr;
        logic [15:0] wdata;
        logic        wub_n;
        logic        wlb_n;
        logic [17:0] raddr;
        logic        rub_n;
        logic        rlb_n;
        logic [15:0] exp_dq;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    wire  [15:0] SRAM_DQ;
    logic        tb_drv;
    logic [15:0] tb_dq;
    logic        rd_valid;
    logic        wr_commit;
    logic        protocol_err;
    int          checks = 0;
    int          errors = 0;
    vec_t        vecs[8];

    sram_device_model_if u_if ();

    assign SRAM_DQ = tb_drv ? tb_dq : 16'hzzzz;
    pullup (SRAM_DQ);

    always #5 clk = ~clk;

    sram_device_model #(.MEM_DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (u_if),
        .SRAM_DQ      (SRAM_DQ),
        .rd_valid     (rd_valid),
        .wr_commit    (wr_commit),
        .protocol_err (protocol_err)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        u_if.SRAM_CE_N = 1'b1;
        u_if.SRAM_WE_N = 1'b1;
        u_if.SRAM_OE_N = 1'b1;
        u_if.SRAM_UB_N = 1'b0;
        u_if.SRAM_LB_N = 1'b0;
        tb_drv         = 1'b0;
    endtask

    task automatic start_write(input logic [17:0] a, input logic [15:0] d, input logic ub_n, input logic lb_n);
        u_if.SRAM_ADDR = a;
        u_if.SRAM_UB_N = ub_n;
        u_if.SRAM_LB_N = lb_n;
        tb_dq          = d;
        tb_drv         = 1'b1;
        u_if.SRAM_OE_N = 1'b1;
        u_if.SRAM_CE_N = 1'b0;
        u_if.SRAM_WE_N = 1'b0;
    endtask

    // WE_N low for two sampled edges, then high: pulse expected exactly one edge later
    task automatic do_write(input logic [17:0] a, input logic [15:0] d, input logic ub_n, input logic lb_n,
                            input string tag);
        start_write(a, d, ub_n, lb_n);
        tick();
        tick();
        chk({tag, " commit_early"}, {15'd0, wr_commit}, 16'd0);
        go_idle();
        tick();
        chk({tag, " commit_pulse"}, {15'd0, wr_commit}, 16'd1);
        tick();
        chk({tag, " commit_end"}, {15'd0, wr_commit}, 16'd0);
    endtask

    task automatic do_read(input logic [17:0] a, input logic ub_n, input logic lb_n, input logic [15:0] exp,
                           input string tag);
        u_if.SRAM_ADDR = a;
        u_if.SRAM_UB_N = ub_n;
        u_if.SRAM_LB_N = lb_n;
        tb_drv         = 1'b0;
        u_if.SRAM_CE_N = 1'b0;
        u_if.SRAM_WE_N = 1'b1;
        u_if.SRAM_OE_N = 1'b0;
        repeat (RL) tick();
        chk({tag, " valid_early"}, {15'd0, rd_valid}, 16'd0);
        chk({tag, " dq_early"}, SRAM_DQ, 16'hFFFF);
        tick();
        chk({tag, " valid"}, {15'd0, rd_valid}, 16'd1);
        chk({tag, " dq"}, SRAM_DQ, exp);
        tick();
        chk({tag, " dq_hold"}, SRAM_DQ, exp);
        go_idle();
        tick();
        chk({tag, " valid_off"}, {15'd0, rd_valid}, 16'd0);
        chk({tag, " dq_off"}, SRAM_DQ, 16'hFFFF);
    endtask

    initial begin
        vecs[0] = '{1'b1, 18'd5,    16'hABCD, 1'b0, 1'b0, 18'd5,    1'b0, 1'b0, 16'hABCD};
        vecs[1] = '{1'b1, 18'd7,    16'h0000, 1'b0, 1'b0, 18'd7,    1'b0, 1'b0, 16'h0000};
        vecs[2] = '{1'b1, 18'd7,    16'h1234, 1'b0, 1'b1, 18'd7,    1'b0, 1'b0, 16'h1200};
        vecs[3] = '{1'b0, 18'd0,    16'h0000, 1'b1, 1'b1, 18'd7,    1'b0, 1'b1, 16'h12FF};
        vecs[4] = '{1'b1, 18'd1028, 16'hBEEF, 1'b0, 1'b0, 18'd4,    1'b0, 1'b0, 16'hBEEF};
        vecs[5] = '{1'b0, 18'd0,    16'h0000, 1'b1, 1'b1, 18'd5,    1'b1, 1'b0, 16'hFFCD};
        vecs[6] = '{1'b1, 18'd4,    16'h00A5, 1'b1, 1'b0, 18'd1028, 1'b0, 1'b0, 16'hBEA5};
        vecs[7] = '{1'b0, 18'd0,    16'h0000, 1'b1, 1'b1, 18'd7,    1'b1, 1'b1, 16'hFFFF};

        rst            = 1'b1;
        tb_dq          = 16'h0000;
        u_if.SRAM_ADDR = 18'd0;
        go_idle();
        tick();
        tick();
        chk("reset rd_valid", {15'd0, rd_valid}, 16'd0);
        chk("reset wr_commit", {15'd0, wr_commit}, 16'd0);
        chk("reset protocol_err", {15'd0, protocol_err}, 16'd0);
        chk("reset dq", SRAM_DQ, 16'hFFFF);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].do_wr) begin
                do_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wub_n, vecs[i].wlb_n, $sformatf("v%0d wr", i));
            end
            do_read(vecs[i].raddr, vecs[i].rub_n, vecs[i].rlb_n, vecs[i].exp_dq, $sformatf("v%0d rd", i));
        end
        chk("legal traffic protocol_err", {15'd0, protocol_err}, 16'd0);

        // Read-after-write: WE_N rises straight into a read of the same word
        start_write(18'd9, 16'h1111, 1'b0, 1'b0);
        tick();
        tick();
        u_if.SRAM_WE_N = 1'b1;
        u_if.SRAM_OE_N = 1'b0;
        tb_drv         = 1'b0;
        tick();
        chk("raw commit", {15'd0, wr_commit}, 16'd1);
        repeat (RL - 1) tick();
        chk("raw valid_early", {15'd0, rd_valid}, 16'd0);
        tick();
        chk("raw valid", {15'd0, rd_valid}, 16'd1);
        chk("raw dq", SRAM_DQ, 16'h1111);
        go_idle();
        tick();

        // Address change mid-read restarts the latency count on the new word
        do_write(18'd10, 16'h0A0A, 1'b0, 1'b0, "pre10");
        do_write(18'd11, 16'h0B0B, 1'b0, 1'b0, "pre11");
        u_if.SRAM_ADDR = 18'd10;
        u_if.SRAM_CE_N = 1'b0;
        u_if.SRAM_OE_N = 1'b0;
        tick();
        tick();
        u_if.SRAM_ADDR = 18'd11;
        for (int k = 0; k < RL; k++) begin
            tick();
            chk($sformatf("achg wait%0d valid", k), {15'd0, rd_valid}, 16'd0);
            chk($sformatf("achg wait%0d dq", k), SRAM_DQ, 16'hFFFF);
        end
        tick();
        chk("achg valid", {15'd0, rd_valid}, 16'd1);
        chk("achg dq", SRAM_DQ, 16'h0B0B);
        go_idle();
        tick();

        // WE_N held low across an address change merges into one commit
        do_write(18'd20, 16'h2020, 1'b0, 1'b0, "pre20");
        start_write(18'd20, 16'h0001, 1'b0, 1'b0);
        tick();
        u_if.SRAM_ADDR = 18'd21;
        tb_dq          = 16'h0002;
        tick();
        chk("merge hold commit", {15'd0, wr_commit}, 16'd0);
        tick();
        go_idle();
        tick();
        chk("merge commit", {15'd0, wr_commit}, 16'd1);
        tick();
        chk("merge commit_end", {15'd0, wr_commit}, 16'd0);
        tick();
        chk("merge single pulse", {15'd0, wr_commit}, 16'd0);
        do_read(18'd21, 1'b0, 1'b0, 16'h0002, "merge rd21");
        do_read(18'd20, 1'b0, 1'b0, 16'h2020, "merge rd20");

        // Reset during a held write discards it
        do_write(18'd3, 16'h3333, 1'b0, 1'b0, "pre3");
        start_write(18'd3, 16'h5555, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        go_idle();
        #1;
        chk("rstw wr_commit", {15'd0, wr_commit}, 16'd0);
        chk("rstw protocol_err", {15'd0, protocol_err}, 16'd0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("rstw no_commit%0d", k), {15'd0, wr_commit}, 16'd0);
        end
        do_read(18'd3, 1'b0, 1'b0, 16'h3333, "rstw rd3");

        // Asynchronous reset while driving a read releases DQ without a clock edge
        u_if.SRAM_ADDR = 18'd5;
        u_if.SRAM_CE_N = 1'b0;
        u_if.SRAM_OE_N = 1'b0;
        repeat (RL + 1) tick();
        chk("rstr valid_before", {15'd0, rd_valid}, 16'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstr valid", {15'd0, rd_valid}, 16'd0);
        chk("rstr dq", SRAM_DQ, 16'hFFFF);
        go_idle();
        tick();
        rst = 1'b0;
        tick();

        // Write asserted while this block drives DQ
        u_if.SRAM_ADDR = 18'd5;
        u_if.SRAM_CE_N = 1'b0;
        u_if.SRAM_OE_N = 1'b0;
        repeat (RL + 1) tick();
        chk("cont valid_before", {15'd0, rd_valid}, 16'd1);
        chk("cont dq_before", SRAM_DQ, 16'hABCD);
        u_if.SRAM_WE_N = 1'b0;
        tick();
        chk("cont valid", {15'd0, rd_valid}, 16'd0);
        chk("cont dq", SRAM_DQ, 16'hFFFF);
        chk("cont protocol_err", {15'd0, protocol_err}, {15'd0, PROT_EXP});
        go_idle();
        tick();
        tick();
        tick();
        chk("cont protocol_err sticky", {15'd0, protocol_err}, {15'd0, PROT_EXP});
        rst = 1'b1;
        #1;
        chk("cont protocol_err cleared", {15'd0, protocol_err}, 16'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
